data_mem_ctrl: RTL and testbench

Responder for the memory-control outputs of the instruction decoder. It takes memread, memwrite and memtoreg with a request strobe, then runs a multi-cycle access to a word-addressed data RAM with a programmable wait-state count. It returns read data, a write-back value (memory data or ALU result) and a one-cycle completion pulse. It sits between the decoder/ALU and the register-file write port.

---
 rtl/data_mem_ctrl.sv | 130 +++++++++++++
 tb/tb_data_mem_ctrl.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/data_mem_ctrl.sv
// Multi-cycle data-memory responder driven by the decoder's memread/memwrite/
// memtoreg controls. Performs one load, store or pass-through per request, with
// a programmable wait-state count, and returns read data plus the write-back value.
module data_mem_ctrl #(
  parameter int unsigned width   = 32,
  parameter int unsigned addr_w  = 8,
  parameter int unsigned latency = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req,
  input  logic              memread,
  input  logic              memwrite,
  input  logic              memtoreg,
  input  logic [addr_w-1:0] addr,
  input  logic [width-1:0]  wdata,
  input  logic [width-1:0]  alu_result,
  output logic              busy,
  output logic              done,
  output logic [width-1:0]  rdata,
  output logic [width-1:0]  wb_data,
  output logic              err
);

  localparam int unsigned CNT_W = 4;
  localparam int unsigned DEPTH = 1 << addr_w;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t              state_q;
  logic [CNT_W-1:0]    cnt_q;
  logic [addr_w-1:0]   addr_q;
  logic [width-1:0]    wdata_q;
  logic [width-1:0]    alu_q;
  logic                mtr_q;
  logic                store_q;
  logic                busy_q;
  logic                done_q;
  logic                err_q;
  logic [width-1:0]    rdata_q;
  logic [width-1:0]    wb_q;
  logic                mem_we;

  logic [width-1:0]    mem [DEPTH];

  // Store commits on the final wait-state edge; reset on that same edge aborts it.
  assign mem_we = rst_n && (state_q == S_WAIT) && (cnt_q == '0) && store_q;

  // RAM write port; contents survive reset.
  always_ff @(posedge clk) begin
    if (mem_we) begin
      mem[addr_q] <= wdata_q;
    end
  end

  // Request sequencing: accept in IDLE, count wait states, pulse done/err.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      alu_q   <= '0;
      mtr_q   <= 1'b0;
      store_q <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
      rdata_q <= '0;
      wb_q    <= '0;
    end else begin
      done_q <= 1'b0;
      err_q  <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (req) begin
            addr_q  <= addr;
            wdata_q <= wdata;
            alu_q   <= alu_result;
            mtr_q   <= memtoreg;
            store_q <= memwrite;
            if (memread && memwrite) begin
              err_q <= 1'b1;
            end else if (!memread && !memwrite) begin
              wb_q    <= alu_result;
              done_q  <= 1'b1;
              state_q <= S_DONE;
            end else begin
              cnt_q   <= CNT_W'(latency - 1);
              busy_q  <= 1'b1;
              state_q <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt_q == '0) begin
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            state_q <= S_DONE;
            if (store_q) begin
              wb_q <= alu_q;
            end else begin
              rdata_q <= mem[addr_q];
              wb_q    <= mtr_q ? mem[addr_q] : alu_q;
            end
          end else begin
            cnt_q <= cnt_q - CNT_W'(1);
          end
        end
        S_DONE: begin
          state_q <= S_IDLE;
        end
        default: begin
          state_q <= S_IDLE;
        end
      endcase
    end
  end

  assign busy    = busy_q;
  assign done    = done_q;
  assign err     = err_q;
  assign rdata   = rdata_q;
  assign wb_data = wb_q;

endmodule

// File: tb/tb_data_mem_ctrl.sv
// Scoreboard bench for data_mem_ctrl: three instances (latency 2, 1, 15) share
// one stimulus stream; a monitor checks each instance against a queue of
// expected responses computed from an associative-array memory model.
module tb_data_mem_ctrl;

  localparam int unsigned W  = 32;
  localparam int unsigned AW = 8;
  localparam int NI = 3;
  localparam int LAT [NI] = '{2, 1, 15};

  typedef enum int {K_MEM, K_PASS, K_ERR} kind_e;
  typedef struct {
    kind_e          kind;
    int             due;
    logic [W-1:0]   wb;
    logic [W-1:0]   rd;
  } exp_t;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          req, memread, memwrite, memtoreg;
  logic [AW-1:0] addr;
  logic [W-1:0]  wdata, alu_result;

  logic          busy_w [NI];
  logic          done_w [NI];
  logic          err_w  [NI];
  logic [W-1:0]  rdata_w [NI];
  logic [W-1:0]  wb_w    [NI];

  exp_t          sbq [NI][$];
  logic [W-1:0]  ref_mem [int];
  logic [W-1:0]  m_rdata, m_wb;

  int  n_total = 0;
  int  n_pass  = 0;
  int  cyc     = 0;
  bit  mon_en  = 1'b0;

  always #5 clk = ~clk;

  data_mem_ctrl #(.width(W), .addr_w(AW), .latency(2)) u_lat2 (
    .clk(clk), .rst_n(rst_n), .req(req), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .addr(addr), .wdata(wdata), .alu_result(alu_result),
    .busy(busy_w[0]), .done(done_w[0]), .rdata(rdata_w[0]), .wb_data(wb_w[0]), .err(err_w[0]));

  data_mem_ctrl #(.width(W), .addr_w(AW), .latency(1)) u_lat1 (
    .clk(clk), .rst_n(rst_n), .req(req), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .addr(addr), .wdata(wdata), .alu_result(alu_result),
    .busy(busy_w[1]), .done(done_w[1]), .rdata(rdata_w[1]), .wb_data(wb_w[1]), .err(err_w[1]));

  data_mem_ctrl #(.width(W), .addr_w(AW), .latency(15)) u_lat15 (
    .clk(clk), .rst_n(rst_n), .req(req), .memread(memread), .memwrite(memwrite),
    .memtoreg(memtoreg), .addr(addr), .wdata(wdata), .alu_result(alu_result),
    .busy(busy_w[2]), .done(done_w[2]), .rdata(rdata_w[2]), .wb_data(wb_w[2]), .err(err_w[2]));

  function automatic void chk(string name, int inst, logic [W-1:0] act, logic [W-1:0] expv);
    n_total++;
    if (act === expv) n_pass++;
    else $display("FAIL %s lat=%0d cycle=%0d: got %h, expected %h", name, LAT[inst], cyc, act, expv);
  endfunction

  // Monitor: per-cycle busy check, and pop/compare whenever done or err shows up.
  always @(negedge clk) begin
    exp_t e;
    bit   eb;
    cyc++;
    if (mon_en) begin
      for (int i = 0; i < NI; i++) begin
        eb = (sbq[i].size() > 0) && (sbq[i][0].kind == K_MEM) && (cyc < sbq[i][0].due);
        chk("busy", i, W'(busy_w[i]), W'(eb));
        if (done_w[i] || err_w[i]) begin
          if (sbq[i].size() == 0) begin
            chk("unexpected_done_or_err", i, W'(1), W'(0));
          end else begin
            e = sbq[i].pop_front();
            chk("completion_cycle", i, W'(cyc), W'(e.due));
            chk("err", i, W'(err_w[i]), W'(e.kind == K_ERR));
            chk("done", i, W'(done_w[i]), W'(e.kind != K_ERR));
            if (e.kind != K_ERR) begin
              chk("wb_data", i, wb_w[i], e.wb);
              chk("rdata", i, rdata_w[i], e.rd);
            end
          end
        end else if (sbq[i].size() > 0 && cyc >= sbq[i][0].due) begin
          chk("missing_completion", i, W'(0), W'(1));
          void'(sbq[i].pop_front());
        end
      end
    end
  end

  task automatic flush_all();
    for (int i = 0; i < NI; i++) sbq[i].delete();
  endtask

  task automatic wait_idle();
    int n = 0;
    bit any;
    any = 1'b1;
    while (any && n < 200) begin
      any = 1'b0;
      for (int i = 0; i < NI; i++) if (sbq[i].size() > 0) any = 1'b1;
      if (any) begin
        @(posedge clk);
        n++;
      end
    end
    if (any) begin
      chk("wait_timeout", 0, W'(0), W'(1));
      flush_all();
    end
  endtask

  task automatic check_reset_outputs(string tag);
    @(negedge clk);
    for (int i = 0; i < NI; i++) begin
      chk({tag, "_busy"}, i, W'(busy_w[i]), W'(0));
      chk({tag, "_done"}, i, W'(done_w[i]), W'(0));
      chk({tag, "_err"},  i, W'(err_w[i]),  W'(0));
      chk({tag, "_rdata"}, i, rdata_w[i], W'(0));
      chk({tag, "_wb"},    i, wb_w[i],    W'(0));
    end
  endtask

  // One request; optional collision pulse during WAIT, or reset during WAIT.
  task automatic issue(input logic rd, input logic wr, input logic mtr,
                       input logic [AW-1:0] a, input logic [W-1:0] wd,
                       input logic [W-1:0] alu, input bit collide, input bit rst_mid);
    exp_t  e;
    kind_e k;
    wait_idle();
    @(posedge clk); #1;
    req = 1'b1; memread = rd; memwrite = wr; memtoreg = mtr;
    addr = a; wdata = wd; alu_result = alu;
    @(posedge clk); #1;
    if (rd && wr) begin
      k = K_ERR;
    end else if (!rd && !wr) begin
      k = K_PASS;
      m_wb = alu;
    end else if (rd) begin
      k = K_MEM;
      m_rdata = ref_mem[int'(a)];
      m_wb = mtr ? m_rdata : alu;
    end else begin
      k = K_MEM;
      if (!rst_mid) ref_mem[int'(a)] = wd;
      m_wb = alu;
    end
    for (int i = 0; i < NI; i++) begin
      e.kind = k;
      e.due  = cyc + 1 + ((k == K_MEM) ? LAT[i] : 0);
      e.wb   = m_wb;
      e.rd   = m_rdata;
      sbq[i].push_back(e);
    end
    req = 1'b0;
    memread = 1'($urandom); memwrite = 1'($urandom); memtoreg = 1'($urandom);
    addr = AW'($urandom); wdata = $urandom; alu_result = $urandom;
    if (rst_mid) begin
      rst_n = 1'b0;
      @(posedge clk);
      flush_all();
      m_rdata = '0;
      m_wb    = '0;
      @(posedge clk); #1;
      rst_n = 1'b1;
      check_reset_outputs("mid_reset");
    end else if (collide && !(rd && wr)) begin
      req = 1'b1; memread = 1'b0; memwrite = 1'b1; addr = a; wdata = $urandom;
      @(posedge clk); #1;
      req = 1'b0;
    end
  endtask

  initial begin
    int op;
    logic [AW-1:0] a;
    rst_n = 1'b0;
    for (int c = 0; c < 2; c++) begin
      req = 1'($urandom); memread = 1'($urandom); memwrite = 1'($urandom);
      memtoreg = 1'($urandom); addr = AW'($urandom); wdata = $urandom; alu_result = $urandom;
      @(posedge clk); #1;
    end
    req = 1'b0;
    rst_n = 1'b1;
    m_rdata = '0;
    m_wb = '0;
    check_reset_outputs("reset");
    mon_en = 1'b1;

    for (int j = 0; j < 16; j++) issue(1'b0, 1'b1, 1'($urandom), AW'(j), $urandom, $urandom, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 8'hFF, 32'hA5A5_A5A5, $urandom, 1'b0, 1'b0);

    issue(1'b0, 1'b1, 1'bx, 8'h05, 32'hDEAD_BEEF, 32'h0000_1111, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 8'h05, $urandom, 32'h0000_2222, 1'b0, 1'b0);
    issue(1'b0, 1'b0, 1'b0, 8'h05, $urandom, 32'h0000_0042, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 8'h05, $urandom, $urandom, 1'b0, 1'b0);
    issue(1'b1, 1'b1, 1'b1, 8'h07, 32'hBAD0_BAD0, $urandom, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 8'h07, $urandom, $urandom, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 8'h03, $urandom, $urandom, 1'b1, 1'b0);
    issue(1'b1, 1'b0, 1'b1, 8'h03, $urandom, $urandom, 1'b0, 1'b0);
    issue(1'b0, 1'b1, 1'b0, 8'hFF, 32'h1234_5678, $urandom, 1'b0, 1'b1);
    issue(1'b1, 1'b0, 1'b1, 8'hFF, $urandom, $urandom, 1'b0, 1'b0);
    issue(1'b1, 1'b0, 1'b0, 8'hFF, $urandom, 32'h0BAD_F00D, 1'b0, 1'b0);

    for (int n = 0; n < 60; n++) begin
      op = $urandom_range(0, 9);
      a  = ($urandom_range(0, 4) == 0) ? 8'hFF : AW'($urandom_range(0, 15));
      case (op)
        0, 1, 2, 3: issue(1'b1, 1'b0, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 2) == 0, 1'b0);
        4, 5, 6:    issue(1'b0, 1'b1, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 2) == 0, 1'b0);
        7:          issue(1'b0, 1'b0, 1'($urandom), a, $urandom, $urandom, $urandom_range(0, 1) == 0, 1'b0);
        8:          issue(1'b1, 1'b1, 1'($urandom), a, $urandom, $urandom, 1'b0, 1'b0);
        default:    issue(1'b0, 1'b1, 1'($urandom), a, $urandom, $urandom, 1'b0, 1'b1);
      endcase
    end

    wait_idle();
    repeat (3) @(posedge clk);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
